gat_layer_seq: RTL

GAT_LAYER_SEQ -- requirements
Module: gat_layer_seq

---
 rtl/gat_pkg.sv | 19 +
 rtl/feat_skid_fifo.sv | 69 ++++++
 rtl/gat_layer_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gat_pkg.sv
// Shared constants and FSM state type for the GAT layer sequencer.
package gat_pkg;

  // Default feature buffer geometry: 2708 nodes x 16 words per node, 32-bit words.
  localparam int GAT_DEFAULT_DEPTH = 43328;
  localparam int GAT_DEFAULT_WIDTH = 32;

  // Output buffer depth; the read throttle assumes exactly two entries.
  localparam int GAT_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOAD = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_NEXT      = 3'd4
  } gat_state_e;

endpackage

// File: rtl/feat_skid_fifo.sv
// Two-entry FIFO that absorbs BRAM read latency in front of the result stream.
// The head entry drives the stream directly, so it stays stable while stalled.
module feat_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] data_q [2];
  logic [WIDTH-1:0] data_d [2];
  logic [1:0]       last_q;
  logic [1:0]       last_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & last_q[rd_ptr_q];
  assign occ       = occ_q;
  assign pop       = out_valid & pop_ready;

  // Next-state: write at the tail on push, advance the head on accepted pop.
  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      data_d[wr_ptr_q] = push_data;
      last_d[wr_ptr_q] = push_last;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  // Storage and pointers; reset empties the buffer and clears the head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: rtl/gat_layer_seq.sv
// Two-layer GAT run sequencer: waits for host loads, lets the core compute,
// then streams the feature BRAM out through a two-entry buffer.
module gat_layer_seq
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_DEPTH  = GAT_DEFAULT_DEPTH,
  parameter int NEW_FEATURE_WIDTH  = GAT_DEFAULT_WIDTH,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          h_data_bram_load_done,
  input  logic                          h_node_info_bram_load_done,
  input  logic                          wgt_bram_load_done,
  output logic                          gat_layer,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_feat_data,
  output logic                          m_feat_valid,
  output logic                          m_feat_last,
  input  logic                          m_feat_ready,
  output logic                          busy,
  output logic                          done
);

  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_ADDR = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

  gat_state_e                    state_q, state_d;
  logic                          gat_layer_q, gat_layer_d;
  logic [NEW_FEATURE_ADDR_W-1:0] word_addr_q, word_addr_d;
  logic                          all_issued_q, all_issued_d;
  logic                          inflight_q, inflight_d;
  logic                          inflight_last_q, inflight_last_d;
  logic                          load_all_prev_q;
  logic                          gat_ready_prev_q;

  logic       load_all;
  logic       load_rise;
  logic       ready_rise;
  logic       pop;
  logic       issue;
  logic [1:0] occ;
  logic [2:0] fill;

  assign load_all   = h_data_bram_load_done & h_node_info_bram_load_done & wgt_bram_load_done;
  assign load_rise  = load_all & ~load_all_prev_q;
  assign ready_rise = gat_ready & ~gat_ready_prev_q;
  assign pop        = m_feat_valid & m_feat_ready;

  // A read may go out only if its word is guaranteed a FIFO slot on return.
  assign fill  = {1'b0, occ} + {2'b00, inflight_q};
  assign issue = (state_q == ST_DRAIN) && !all_issued_q && (fill < (3'd2 + {2'b00, pop}));

  assign feat_bram_addrb = {word_addr_q, 2'b00};
  assign gat_layer       = gat_layer_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_NEXT) && gat_layer_q;

  // FSM, read address counter and in-flight tracking.
  always_comb begin
    state_d         = state_q;
    gat_layer_d     = gat_layer_q;
    word_addr_d     = word_addr_q;
    all_issued_d    = all_issued_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_LOAD;
      end
      ST_WAIT_LOAD: begin
        if (load_rise) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ready_rise) begin
          state_d      = ST_DRAIN;
          word_addr_d  = '0;
          all_issued_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (issue) begin
          inflight_d      = 1'b1;
          inflight_last_d = (word_addr_q == LAST_ADDR);
          // Park on the last address instead of wrapping.
          if (word_addr_q == LAST_ADDR) all_issued_d = 1'b1;
          else                          word_addr_d  = word_addr_q + 1'b1;
        end
        if (pop && m_feat_last) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (gat_layer_q) begin
          gat_layer_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          gat_layer_d = 1'b1;
          state_d     = ST_WAIT_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers, including the edge-detect history of the host/core levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      gat_layer_q      <= 1'b0;
      word_addr_q      <= '0;
      all_issued_q     <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_last_q  <= 1'b0;
      load_all_prev_q  <= 1'b0;
      gat_ready_prev_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      gat_layer_q      <= gat_layer_d;
      word_addr_q      <= word_addr_d;
      all_issued_q     <= all_issued_d;
      inflight_q       <= inflight_d;
      inflight_last_q  <= inflight_last_d;
      load_all_prev_q  <= load_all;
      gat_ready_prev_q <= gat_ready;
    end
  end

  feat_skid_fifo #(
    .WIDTH(NEW_FEATURE_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (feat_bram_dout),
    .push_last (inflight_last_q),
    .pop_ready (m_feat_ready),
    .out_data  (m_feat_data),
    .out_valid (m_feat_valid),
    .out_last  (m_feat_last),
    .occ       (occ)
  );

endmodule
